// File: rtl/rtc_write_if.sv
// Request/status/serial bundle for the DS1302 write engine.
// The master side issues requests; rtc_write sits on the slave side.
interface rtc_write_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_ram;
    logic [4:0] req_addr;
    logic [7:0] req_data;
    logic       busy;
    logic       done;
    logic       rtc_ce;
    logic       rtc_clk;
    logic       rtc_dout;
    logic       rtc_oe;

    modport master (
        output req_valid, req_ram, req_addr, req_data,
        input  req_ready, busy, done, rtc_ce, rtc_clk, rtc_dout, rtc_oe
    );

    modport slave (
        input  req_valid, req_ram, req_addr, req_data,
        output req_ready, busy, done, rtc_ce, rtc_clk, rtc_dout, rtc_oe
    );
endinterface

// File: rtl/rtc_write.sv
// DS1302 write engine: serialises one {cmd, data} frame LSB first onto CE/SCLK/IO.
// Every rtc_* output is a flop loaded from next-state values, so req_* never reaches the pins.
module rtc_write #(
    parameter int CLK_DIV  = 50,
    parameter int CE_SETUP = 200,
    parameter int CE_HOLD  = 50,
    parameter int CE_GAP   = 200
) (
    input  logic        sclk,
    input  logic        rst,
    rtc_write_if.slave  bus
);
    localparam int M1   = (CLK_DIV > CE_SETUP) ? CLK_DIV : CE_SETUP;
    localparam int M2   = (CE_HOLD > CE_GAP) ? CE_HOLD : CE_GAP;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic          hi_q, hi_d;
    logic [15:0]   frame_q, frame_d;
    logic          ce_q, ce_d;
    logic          clk_q, clk_d;
    logic          dout_q, dout_d;
    logic          oe_q, oe_d;
    logic          done_q, done_d;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            hi_q    <= 1'b0;
            frame_q <= '0;
            ce_q    <= 1'b0;
            clk_q   <= 1'b0;
            dout_q  <= 1'b0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            hi_q    <= hi_d;
            frame_q <= frame_d;
            ce_q    <= ce_d;
            clk_q   <= clk_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        hi_d    = hi_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    // Command byte {1,ram,addr,0}: bit0 = 0 selects a write.
                    frame_d = {bus.req_data, 1'b1, bus.req_ram, bus.req_addr, 1'b0};
                    state_d = SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    hi_d    = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(CE_SETUP - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    hi_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!hi_q) begin
                        hi_d = 1'b1;
                    end else if (bit_q == 4'd15) begin
                        state_d = HOLD;
                        hi_d    = 1'b0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        hi_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == CW'(CE_HOLD - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(CE_GAP - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin values follow the next state so they change on the same edge as the FSM.
    always_comb begin
        ce_d   = (state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD);
        oe_d   = ce_d;
        clk_d  = (state_d == SHIFT) && hi_d;
        done_d = (state_q == GAP) && (state_d == IDLE);
        dout_d = 1'b0;
        if ((state_d == SETUP) || (state_d == SHIFT))
            dout_d = frame_d[bit_d];
        else if (state_d == HOLD)
            dout_d = dout_q;
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.rtc_ce    = ce_q;
    assign bus.rtc_clk   = clk_q;
    assign bus.rtc_dout  = dout_q;
    assign bus.rtc_oe    = oe_q;
endmodule
